// File: rtl/vram_ctl.sv
// ---------------------------------------------------------------------------
// vram_ctl -- text-mode video RAM controller
//
// Owns the single port of the shared video RAM. LCD character fetches get the
// port with absolute priority; every cycle without a fetch is used by a small
// FSM that runs terminal commands from a byte-stream host: printable write
// with cursor advance, CR / LF / BS, clear screen (FF) and hardware scroll.
//
// Optional feature macro: VRAM_CURSOR_EN
//   defined     -> blinking '_' cursor overlaid on LCD fetches at the cursor
//                  address while the controller is idle.
//   not defined -> LCD data is always the raw RAM data.
//
// Parameters:
//   COLS      characters per row
//   ROWS      rows per screen (COLS*ROWS <= 4096)
//   BLINK_DIV cursor blink half-period is 2**BLINK_DIV clocks (cursor only)
//
// Ports:
//   i_clk        system clock (same clock as the video RAM)
//   i_reset_n    asynchronous active-low reset
//   i_lcd_req    LCD fetch strobe, one cycle per character
//   i_lcd_addr   LCD fetch address
//   o_lcd_data   fetched character, valid 2 cycles after the request, held
//   i_wr_valid   host byte valid (host holds it until accepted)
//   i_wr_char    host byte
//   o_wr_ready   controller accepts a byte this cycle
//   o_busy       controller is executing a command (state != IDLE)
//   o_ram_addr   video RAM address
//   o_ram_we     video RAM write enable
//   o_ram_wdata  video RAM write data
//   i_ram_rdata  video RAM read data, one clock after the address
// ---------------------------------------------------------------------------
module vram_ctl #(
    parameter int COLS      = 106,
    parameter int ROWS      = 36,
    parameter int BLINK_DIV = 24
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_lcd_req,
    input  logic [11:0] i_lcd_addr,
    output logic [7:0]  o_lcd_data,
    input  logic        i_wr_valid,
    input  logic [7:0]  i_wr_char,
    output logic        o_wr_ready,
    output logic        o_busy,
    output logic [11:0] o_ram_addr,
    output logic        o_ram_we,
    output logic [7:0]  o_ram_wdata,
    input  logic [7:0]  i_ram_rdata
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [11:0] LAST_ADDR     = 12'(COLS * ROWS - 1);
    localparam logic [11:0] LAST_ROW_ADDR = 12'((ROWS - 1) * COLS);
    localparam logic [11:0] COLS_A        = 12'(COLS);
    localparam logic [CW-1:0] LAST_COL    = CW'(COLS - 1);
    localparam logic [RW-1:0] LAST_ROW    = RW'(ROWS - 1);

    typedef enum logic [2:0] {
        S_RESET_CLR,
        S_IDLE,
        S_WRITE,
        S_SCR_RD,
        S_SCR_WR,
        S_CLR
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [11:0]   r_caddr;      // row*COLS+col, kept incrementally
    logic [11:0]   r_ptr;        // clear address / scroll source address
    logic [7:0]    r_char;       // latched printable byte
    logic [11:0]   r_last_addr;  // last FSM address, parked on the port in IDLE
    logic          r_rd_pending; // a granted scroll read returns data this cycle
    logic [7:0]    r_scr_data;   // scroll holding register
    logic          r_lcd_pending;
    logic [7:0]    r_lcd_data;

    logic          w_grant;
    logic [11:0]   w_fsm_addr;
    logic          w_fsm_we;
    logic [7:0]    w_fsm_wdata;
    logic          w_lcd_cur;

    // ------------------------------------------------------------------
    // FSM port request, decoded from the current state
    // ------------------------------------------------------------------
    always_comb begin
        w_fsm_addr  = r_last_addr;
        w_fsm_we    = 1'b0;
        w_fsm_wdata = 8'h20;
        case (r_state)
            S_RESET_CLR, S_CLR: begin
                w_fsm_addr = r_ptr;
                w_fsm_we   = 1'b1;
            end
            S_WRITE: begin
                w_fsm_addr  = r_caddr;
                w_fsm_we    = 1'b1;
                w_fsm_wdata = r_char;
            end
            S_SCR_RD: begin
                w_fsm_addr = r_ptr;
            end
            S_SCR_WR: begin
                w_fsm_addr  = r_ptr - COLS_A;
                w_fsm_we    = 1'b1;
                // Right after the read the data is still on the RAM bus; if
                // the write was stalled it comes from the holding register.
                w_fsm_wdata = r_rd_pending ? i_ram_rdata : r_scr_data;
            end
            default: ;
        endcase
    end

    assign w_grant     = ~i_lcd_req;
    assign o_ram_addr  = i_lcd_req ? i_lcd_addr : w_fsm_addr;
    // No writes while reset is held, even though RESET_CLR is already active.
    assign o_ram_we    = i_reset_n & w_grant & w_fsm_we;
    assign o_ram_wdata = w_fsm_wdata;
    assign o_busy      = (r_state != S_IDLE);
    // A byte is only taken in a cycle the FSM actually owns, so a stalled
    // IDLE cycle never swallows the host byte.
    assign o_wr_ready  = (r_state == S_IDLE) & w_grant;
    assign o_lcd_data  = r_lcd_data;

    // ------------------------------------------------------------------
    // Command FSM; every register holds while the LCD owns the port
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_RESET_CLR;
            r_col       <= '0;
            r_row       <= '0;
            r_caddr     <= '0;
            r_ptr       <= '0;
            r_char      <= 8'h20;
            r_last_addr <= '0;
        end else if (w_grant) begin
            r_last_addr <= w_fsm_addr;
            case (r_state)
                S_RESET_CLR, S_CLR: begin
                    if (r_ptr == LAST_ADDR) r_state <= S_IDLE;
                    else                    r_ptr   <= r_ptr + 12'd1;
                end
                S_IDLE: begin
                    if (i_wr_valid) begin
                        if (i_wr_char >= 8'h20 && i_wr_char <= 8'h7E) begin
                            r_char  <= i_wr_char;
                            r_state <= S_WRITE;
                        end else begin
                            case (i_wr_char)
                                8'h0D: begin
                                    r_col   <= '0;
                                    r_caddr <= r_caddr - 12'(r_col);
                                end
                                8'h0A: begin
                                    if (r_row == LAST_ROW) begin
                                        r_ptr   <= COLS_A;
                                        r_state <= S_SCR_RD;
                                    end else begin
                                        r_row   <= r_row + 1'b1;
                                        r_caddr <= r_caddr + COLS_A;
                                    end
                                end
                                8'h08: begin
                                    if (r_col != '0) begin
                                        r_col   <= r_col - 1'b1;
                                        r_caddr <= r_caddr - 12'd1;
                                    end
                                end
                                8'h0C: begin
                                    r_col   <= '0;
                                    r_row   <= '0;
                                    r_caddr <= '0;
                                    r_ptr   <= '0;
                                    r_state <= S_CLR;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                S_WRITE: begin
                    if (r_col == LAST_COL) begin
                        r_col <= '0;
                        if (r_row == LAST_ROW) begin
                            // Cursor stays on the last row, which the scroll blanks.
                            r_caddr <= LAST_ROW_ADDR;
                            r_ptr   <= COLS_A;
                            r_state <= S_SCR_RD;
                        end else begin
                            r_row   <= r_row + 1'b1;
                            r_caddr <= r_caddr + 12'd1;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_col   <= r_col + 1'b1;
                        r_caddr <= r_caddr + 12'd1;
                        r_state <= S_IDLE;
                    end
                end
                S_SCR_RD: begin
                    r_state <= S_SCR_WR;
                end
                S_SCR_WR: begin
                    if (r_ptr == LAST_ADDR) begin
                        r_ptr   <= LAST_ROW_ADDR;
                        r_state <= S_CLR;
                    end else begin
                        r_ptr   <= r_ptr + 12'd1;
                        r_state <= S_SCR_RD;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Scroll read capture: data arrives the cycle after a granted read
    // and is captured whether or not the LCD owns the port then.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rd_pending <= 1'b0;
            r_scr_data   <= 8'h20;
        end else begin
            r_rd_pending <= (r_state == S_SCR_RD) & w_grant;
            if (r_rd_pending) r_scr_data <= i_ram_rdata;
        end
    end

`ifdef VRAM_CURSOR_EN
    logic [BLINK_DIV:0] r_blink;
    logic               r_lcd_cur;

    // Cursor decision is taken with the request and travels with it.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_blink   <= '0;
            r_lcd_cur <= 1'b0;
        end else begin
            r_blink   <= r_blink + 1'b1;
            r_lcd_cur <= i_lcd_req & (i_lcd_addr == r_caddr) &
                         r_blink[BLINK_DIV] & (r_state == S_IDLE);
        end
    end
    assign w_lcd_cur = r_lcd_cur;
`else
    assign w_lcd_cur = 1'b0;
`endif

    // ------------------------------------------------------------------
    // LCD return path: fixed two-cycle latency, held between fetches
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_lcd_pending <= 1'b0;
            r_lcd_data    <= 8'h00;
        end else begin
            r_lcd_pending <= i_lcd_req;
            if (r_lcd_pending) r_lcd_data <= w_lcd_cur ? 8'h5F : i_ram_rdata;
        end
    end

endmodule

// File: tb/tb_vram_ctl.sv
// ---------------------------------------------------------------------------
// tb_vram_ctl -- self-checking bench for vram_ctl.
// Holds a behavioural RAM, a screen/cursor reference model updated per host
// byte, and a background LCD fetcher whose returned data is checked against
// the RAM contents at request time.
// ---------------------------------------------------------------------------
module tb_vram_ctl;
    localparam int COLS = 106;
    localparam int ROWS = 36;
    localparam int N    = COLS * ROWS;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_lcd_req;
    logic [11:0] i_lcd_addr;
    logic [7:0]  o_lcd_data;
    logic        i_wr_valid = 1'b0;
    logic [7:0]  i_wr_char = 8'h00;
    logic        o_wr_ready;
    logic        o_busy;
    logic [11:0] o_ram_addr;
    logic        o_ram_we;
    logic [7:0]  o_ram_wdata;
    logic [7:0]  ram_q;

    always #5 clk = ~clk;

    vram_ctl #(.COLS(COLS), .ROWS(ROWS), .BLINK_DIV(3)) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_lcd_req   (i_lcd_req),
        .i_lcd_addr  (i_lcd_addr),
        .o_lcd_data  (o_lcd_data),
        .i_wr_valid  (i_wr_valid),
        .i_wr_char   (i_wr_char),
        .o_wr_ready  (o_wr_ready),
        .o_busy      (o_busy),
        .o_ram_addr  (o_ram_addr),
        .o_ram_we    (o_ram_we),
        .o_ram_wdata (o_ram_wdata),
        .i_ram_rdata (ram_q)
    );

    // Behavioural single-port RAM with registered read.
    logic [7:0] ram [0:4095];
    initial for (int i = 0; i < 4096; i++) ram[i] = 8'hEE;
    always @(posedge clk) begin
        if (o_ram_we) ram[o_ram_addr] <= o_ram_wdata;
        ram_q <= ram[o_ram_addr];
    end

    int checks = 0;
    int failures = 0;

    task automatic chk_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: screen array plus cursor, one step per host byte
    // ------------------------------------------------------------------
    logic [7:0] model_mem [0:N-1];
    int m_col = 0;
    int m_row = 0;

    task automatic model_reset();
        for (int i = 0; i < N; i++) model_mem[i] = 8'h20;
        m_col = 0;
        m_row = 0;
    endtask

    task automatic model_scroll();
        for (int i = 0; i < N - COLS; i++) model_mem[i] = model_mem[i + COLS];
        for (int i = N - COLS; i < N; i++) model_mem[i] = 8'h20;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            model_mem[m_row * COLS + m_col] = b;
            m_col++;
            if (m_col == COLS) begin
                m_col = 0;
                if (m_row == ROWS - 1) model_scroll();
                else m_row++;
            end
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h0A) begin
            if (m_row == ROWS - 1) model_scroll();
            else m_row++;
        end else if (b == 8'h08) begin
            if (m_col > 0) m_col--;
        end else if (b == 8'h0C) begin
            model_reset();
        end
    endtask

    function automatic int mem_diffs();
        int d = 0;
        for (int i = 0; i < N; i++) if (ram[i] !== model_mem[i]) d++;
        return d;
    endfunction

    // ------------------------------------------------------------------
    // Background LCD fetcher. Mode 0 off, 1 every other cycle, 2 random,
    // 3 every cycle at fixed_addr (samples recorded in obs_q).
    // ------------------------------------------------------------------
    int lcd_mode = 0;
    logic [11:0] fixed_addr = 12'd0;
    logic [7:0] obs_q [$];

    initial begin
        bit pv1 = 1'b0;
        bit pv2 = 1'b0;
        logic [7:0] pe1 = 8'h00;
        logic [7:0] pe2 = 8'h00;
        i_lcd_req  = 1'b0;
        i_lcd_addr = 12'd0;
        forever begin
            @(negedge clk);
            if (pv2) begin
`ifdef VRAM_CURSOR_EN
                chk_eq("lcd_data", o_lcd_data, (o_lcd_data == 8'h5F) ? 8'h5F : pe2);
`else
                chk_eq("lcd_data", o_lcd_data, pe2);
`endif
            end
            if (lcd_mode == 3) obs_q.push_back(o_lcd_data);
            pv2 = pv1;
            pe2 = pe1;
            case (lcd_mode)
                1:       i_lcd_req = ~i_lcd_req;
                2:       i_lcd_req = 1'($urandom_range(0, 1));
                3:       i_lcd_req = 1'b1;
                default: i_lcd_req = 1'b0;
            endcase
            i_lcd_addr = (lcd_mode == 3) ? fixed_addr : 12'($urandom_range(0, N - 1));
            pv1 = i_lcd_req;
            pe1 = ram[i_lcd_addr];
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    // Main thread always sits at negedge+1 between actions.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        i_wr_valid = 1'b1;
        i_wr_char  = b;
        while (!o_wr_ready && n < 20000) begin
            tick();
            n++;
        end
        if (!o_wr_ready) begin
            chk_eq("ready_timeout", 0, 1);
            i_wr_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            i_wr_valid = 1'b0;
            model_byte(b);
            tick();
        end
    endtask

    // Counts busy cycles in which the FSM owned the port.
    task automatic wait_idle(output int cyc);
        int n = 0;
        cyc = 0;
        while (o_busy && n < 40000) begin
            if (!i_lcd_req) cyc++;
            tick();
            n++;
        end
        if (o_busy) chk_eq("idle_timeout", 0, 1);
    endtask

    task automatic send_wait(input logic [7:0] b, output int cyc);
        send_byte(b);
        wait_idle(cyc);
    endtask

    initial begin
        int cyc;
        int k;
        model_reset();

        // Reset state
        repeat (3) tick();
        chk_eq("rst_ram_we", o_ram_we, 0);
        chk_eq("rst_ram_addr", o_ram_addr, 0);
        chk_eq("rst_ram_wdata", o_ram_wdata, 8'h20);
        chk_eq("rst_wr_ready", o_wr_ready, 0);
        chk_eq("rst_busy", o_busy, 1);
        chk_eq("rst_lcd_data", o_lcd_data, 0);
        rst_n = 1'b1;
        wait_idle(cyc);
        chk_eq("reset_clr_cycles", cyc, N);
        chk_eq("ready_after_clr", o_wr_ready, 1);
        chk_eq("mem_after_reset", mem_diffs(), 0);

        // "AB", CR, LF, "C"
        send_wait(8'h41, cyc); chk_eq("print_cost", cyc, 1);
        send_wait(8'h42, cyc);
        send_wait(8'h0D, cyc); chk_eq("cr_cost", cyc, 0);
        send_wait(8'h0A, cyc); chk_eq("lf_cost", cyc, 0);
        send_wait(8'h43, cyc);
        chk_eq("addr0", ram[0], 8'h41);
        chk_eq("addr1", ram[1], 8'h42);
        chk_eq("addr106", ram[106], 8'h43);
        send_wait(8'h5A, cyc);
        chk_eq("cursor_c1r1", ram[107], 8'h5A);
        chk_eq("mem_directed", mem_diffs(), 0);

        // Scroll without stalls
        send_wait(8'h0C, cyc);
        chk_eq("ff_cycles", cyc, N);
        for (int i = 0; i < ROWS - 1; i++) send_byte(8'h0A);
        for (int i = 0; i < COLS - 1; i++) send_byte(8'h78);
        send_wait(8'h78, cyc);
        chk_eq("scroll_cycles", cyc, 1 + 2 * COLS * (ROWS - 1) + COLS);
        send_wait(8'h79, cyc);
        chk_eq("addr3710", ram[3710], 8'h79);
        k = 0;
        for (int i = 3711; i < N; i++) if (ram[i] != 8'h20) k++;
        chk_eq("last_row_blank", k, 0);
        k = 0;
        for (int i = 35 * COLS - COLS; i < 35 * COLS; i++) if (ram[i] != 8'h78) k++;
        chk_eq("row34_copied", k, 0);
        chk_eq("mem_scroll", mem_diffs(), 0);

        // Scroll with an LCD fetch every other cycle
        lcd_mode = 1;
        for (int i = 0; i < COLS - 2; i++) send_byte(8'h61 + 8'(i % 26));
        send_wait(8'h7A, cyc);
        chk_eq("stall_scroll_steps", cyc, 1 + 2 * COLS * (ROWS - 1) + COLS);
        chk_eq("mem_stall_scroll", mem_diffs(), 0);

        // Random byte stream with random LCD traffic
        lcd_mode = 2;
        send_wait(8'h0C, cyc);
        for (int i = 0; i < 200; i++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 99);
            if (r < 70)      b = 8'($urandom_range(8'h20, 8'h7E));
            else if (r < 78) b = 8'h0D;
            else if (r < 83) b = 8'h0A;
            else if (r < 92) b = 8'h08;
            else begin
                case ($urandom_range(0, 5))
                    0:       b = 8'h00;
                    1:       b = 8'h1B;
                    2:       b = 8'h7F;
                    3:       b = 8'h80;
                    4:       b = 8'h09;
                    default: b = 8'hFF;
                endcase
            end
            send_byte(b);
        end
        wait_idle(cyc);
        chk_eq("mem_random", mem_diffs(), 0);

        // Fill the screen, then FF and BS at column 0
        lcd_mode = 0;
        send_byte(8'h0C);
        for (int i = 0; i < N - 1; i++) send_byte(8'($urandom_range(8'h21, 8'h7E)));
        wait_idle(cyc);
        chk_eq("mem_filled", mem_diffs(), 0);
        send_wait(8'h0C, cyc);
        chk_eq("mem_ff", mem_diffs(), 0);
        send_wait(8'h08, cyc); chk_eq("bs_cost", cyc, 0);
        send_wait(8'h51, cyc);
        chk_eq("bs_at_col0", ram[0], 8'h51);

        // Reset in the middle of a scroll
        for (int i = 0; i < ROWS - 1; i++) send_byte(8'h0A);
        send_byte(8'h6B);
        send_byte(8'h0A);
        repeat (200) tick();
        chk_eq("scrolling_busy", o_busy, 1);
        rst_n = 1'b0;
        repeat (2) tick();
        chk_eq("midrst_busy", o_busy, 1);
        chk_eq("midrst_ready", o_wr_ready, 0);
        rst_n = 1'b1;
        model_reset();
        wait_idle(cyc);
        chk_eq("midrst_clr_cycles", cyc, N);
        chk_eq("mem_midrst", mem_diffs(), 0);
        send_wait(8'h4D, cyc);
        chk_eq("home_after_rst", ram[0], 8'h4D);

`ifdef VRAM_CURSOR_EN
        // Cursor at address 1 (RAM holds 0x20): blink every 8 cycles
        fixed_addr = 12'd1;
        obs_q.delete();
        lcd_mode = 3;
        repeat (45) tick();
        lcd_mode = 0;
        repeat (3) tick();
        k = -1;
        for (int i = 4; i < obs_q.size() && k < 0; i++) if (obs_q[i] != obs_q[i - 1]) k = i;
        chk_eq("blink_toggle_seen", (k > 0) ? 1 : 0, 1);
        if (k > 0 && k + 16 < obs_q.size()) begin
            chk_eq("blink_pair", int'(obs_q[k] ^ obs_q[k - 1]), int'(8'h5F ^ 8'h20));
            for (int j = 0; j < 16; j++)
                chk_eq("blink_run", obs_q[k + j], (j < 8) ? obs_q[k] : obs_q[k - 1]);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
